// File: rtl/spi_master_nss_if.sv
// Register-side controls and SPI pin bundle for spi_master_nss.
// The master modport is the SPI engine's view; slave is the driving side.
interface spi_master_nss_if #(
    parameter int NSS  = 2,
    parameter int DIVW = 4
);
    logic            ss_we;
    logic [NSS-1:0]  ss_in;
    logic [1:0]      mode;
    logic [DIVW-1:0] div;
    logic            start;
    logic [7:0]      txd;
    logic [7:0]      rxd;
    logic            busy;
    logic            done;
    logic [NSS:0]    miso;
    logic            mosi;
    logic            sck;
    logic [NSS-1:0]  nss;

    modport master (
        input  ss_we, ss_in, mode, div, start, txd, miso,
        output rxd, busy, done, mosi, sck, nss
    );

    modport slave (
        output ss_we, ss_in, mode, div, start, txd, miso,
        input  rxd, busy, done, mosi, sck, nss
    );
endinterface

// File: rtl/spi_master_nss.sv
// Byte-wide SPI master: NSS active-low selects, SPI modes 0-3, SCK half period of DIV+1 clocks.
// MISO from all selected devices is OR-mixed; bit NSS is the fallback line when nothing is selected.
module spi_master_nss #(
    parameter int NSS  = 2,
    parameter int DIVW = 4
) (
    input logic              clk,
    input logic              rst,
    spi_master_nss_if.master bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t          state_reg, state_next;
    logic [NSS-1:0]  mask_reg, mask_next;
    logic [1:0]      mode_reg, mode_next;
    logic [DIVW-1:0] div_reg, div_next;
    logic [DIVW-1:0] div_cnt_reg, div_cnt_next;
    logic [3:0]      edge_cnt_reg, edge_cnt_next;
    logic [7:0]      tx_reg, tx_next;
    logic [7:0]      rx_reg, rx_next;
    logic [7:0]      rxd_reg, rxd_next;
    logic            sck_reg, sck_next;
    logic            mosi_reg, mosi_next;

    logic [NSS-1:0]  sel_bits;
    logic            miso_mix;
    logic            half_end;
    logic            leading;
    logic            sample_edge;
    logic            shift_edge;

    genvar gi;
    generate
        for (gi = 0; gi < NSS; gi++) begin : g_mix
            assign sel_bits[gi] = bus.miso[gi] & mask_reg[gi];
        end
    endgenerate

    assign miso_mix = (|sel_bits) | (bus.miso[NSS] & ~(|mask_reg));

    // edge_cnt counts from 0, so an even count is an odd-numbered (leading) edge
    assign half_end    = (div_cnt_reg == div_reg);
    assign leading     = ~edge_cnt_reg[0];
    assign sample_edge = half_end & (leading ^ mode_reg[0]);
    assign shift_edge  = half_end & ~(leading ^ mode_reg[0]);

    always_comb begin
        state_next    = state_reg;
        mask_next     = mask_reg;
        mode_next     = mode_reg;
        div_next      = div_reg;
        div_cnt_next  = div_cnt_reg;
        edge_cnt_next = edge_cnt_reg;
        tx_next       = tx_reg;
        rx_next       = rx_reg;
        rxd_next      = rxd_reg;
        sck_next      = sck_reg;
        mosi_next     = mosi_reg;

        if (bus.ss_we && state_reg != SHIFT) begin
            mask_next = bus.ss_in;
        end

        case (state_reg)
            IDLE: begin
                sck_next  = mode_reg[1];
                mosi_next = 1'b1;
                if (bus.start) begin
                    mode_next     = bus.mode;
                    div_next      = bus.div;
                    div_cnt_next  = '0;
                    edge_cnt_next = 4'd0;
                    rx_next       = 8'h00;
                    sck_next      = bus.mode[1];
                    // CPHA=0 puts the MSB on MOSI before the first edge; CPHA=1 waits for the leading edge
                    if (bus.mode[0]) begin
                        tx_next   = bus.txd;
                        mosi_next = 1'b1;
                    end else begin
                        tx_next   = {bus.txd[6:0], 1'b0};
                        mosi_next = bus.txd[7];
                    end
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (half_end) begin
                    div_cnt_next  = '0;
                    sck_next      = ~sck_reg;
                    edge_cnt_next = edge_cnt_reg + 4'd1;
                    if (sample_edge) begin
                        rx_next = {rx_reg[6:0], miso_mix};
                    end
                    if (shift_edge) begin
                        mosi_next = tx_reg[7];
                        tx_next   = {tx_reg[6:0], 1'b0};
                    end
                    // With CPHA=1 the last edge is also the last sample, so fold it in directly
                    if (edge_cnt_reg == 4'd15) begin
                        rxd_next   = mode_reg[0] ? {rx_reg[6:0], miso_mix} : rx_reg;
                        mosi_next  = 1'b1;
                        state_next = FINISH;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + DIVW'(1);
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            mask_reg     <= '0;
            mode_reg     <= 2'b00;
            div_reg      <= '0;
            div_cnt_reg  <= '0;
            edge_cnt_reg <= 4'd0;
            tx_reg       <= 8'h00;
            rx_reg       <= 8'h00;
            rxd_reg      <= 8'h00;
            sck_reg      <= 1'b0;
            mosi_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            mask_reg     <= mask_next;
            mode_reg     <= mode_next;
            div_reg      <= div_next;
            div_cnt_reg  <= div_cnt_next;
            edge_cnt_reg <= edge_cnt_next;
            tx_reg       <= tx_next;
            rx_reg       <= rx_next;
            rxd_reg      <= rxd_next;
            sck_reg      <= sck_next;
            mosi_reg     <= mosi_next;
        end
    end

    assign bus.rxd  = rxd_reg;
    assign bus.busy = (state_reg == SHIFT);
    assign bus.done = (state_reg == FINISH);
    assign bus.mosi = mosi_reg;
    assign bus.sck  = sck_reg;
    assign bus.nss  = ~mask_reg;
endmodule

// File: tb/tb_spi_master_nss.sv
// Directed bench for spi_master_nss: modes, MISO mixing, divider timing, abort and back-to-back.
module tb_spi_master_nss;
    localparam int NSS  = 2;
    localparam int DIVW = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [NSS:0] miso_drv;
    logic         loopback;
    int           checks = 0;
    int           errors = 0;

    spi_master_nss_if #(.NSS(NSS), .DIVW(DIVW)) bus();

    spi_master_nss #(.NSS(NSS), .DIVW(DIVW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.miso = loopback ? {miso_drv[NSS:1], bus.mosi} : miso_drv;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mask(input logic [NSS-1:0] m);
        bus.ss_in = m;
        bus.ss_we = 1'b1;
        step();
        bus.ss_we = 1'b0;
    endtask

    // Starts a transfer in the current cycle and follows it up to the DONE cycle.
    // Acts as an SPI slave when slave_en is set: shifts 'slave' out on MISO[0] after each sample edge.
    task automatic run_xfer(input logic [7:0] tx, input logic [1:0] md, input logic [DIVW-1:0] dv,
                            input logic [7:0] slave, input bit slave_en, input int poke_at,
                            output int lat, output int rises, output logic [7:0] mosi_seq,
                            output int lvl_min, output int lvl_max,
                            output bit busy_ok, output bit rxd_stable, output bit nss_stable);
        logic [7:0]     rxd_before;
        logic [NSS-1:0] nss_before;
        logic           prev_sck;
        logic           prev_mosi;
        logic           samp_lvl;
        int             nbits;
        int             run;
        rxd_before = bus.rxd;
        nss_before = bus.nss;
        samp_lvl   = ~(md[1] ^ md[0]);
        bus.txd    = tx;
        bus.mode   = md;
        bus.div    = dv;
        bus.ss_we  = 1'b0;
        bus.start  = 1'b1;
        if (slave_en) miso_drv[0] = slave[7];
        step();
        bus.start  = 1'b0;
        lat        = 1;
        rises      = 0;
        nbits      = 0;
        mosi_seq   = 8'h00;
        run        = 1;
        lvl_min    = 1000;
        lvl_max    = 0;
        busy_ok    = 1'b1;
        rxd_stable = 1'b1;
        nss_stable = 1'b1;
        prev_sck   = bus.sck;
        prev_mosi  = bus.mosi;
        while (bus.done !== 1'b1 && lat < 400) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.rxd !== rxd_before) rxd_stable = 1'b0;
            if (bus.nss !== nss_before) nss_stable = 1'b0;
            if (lat == poke_at) begin
                bus.start = 1'b1;
                bus.ss_we = 1'b1;
                bus.ss_in = nss_before;
                bus.mode  = ~md;
                bus.div   = ~dv;
                bus.txd   = ~tx;
            end else begin
                bus.start = 1'b0;
                bus.ss_we = 1'b0;
            end
            step();
            lat++;
            if (bus.sck !== prev_sck) begin
                if (run < lvl_min) lvl_min = run;
                if (run > lvl_max) lvl_max = run;
                run = 1;
                if (bus.sck === 1'b1) rises++;
                if (bus.sck === samp_lvl) begin
                    mosi_seq = {mosi_seq[6:0], prev_mosi};
                    nbits++;
                    if (slave_en && nbits < 8) miso_drv[0] = slave[7 - nbits];
                end
            end else begin
                run++;
            end
            prev_sck  = bus.sck;
            prev_mosi = bus.mosi;
        end
        bus.start = 1'b0;
        bus.ss_we = 1'b0;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ss_we = 1'b0; bus.ss_in = '0; bus.mode = 2'b00; bus.div = '0;
        bus.start = 1'b0; bus.txd = 8'h00;
        miso_drv = '0; loopback = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        checks++; if (bus.nss !== 2'b11) begin errors++; $display("FAIL reset_nss: got %b expected 11", bus.nss); end
        checks++; if (bus.sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", bus.sck); end
        checks++; if (bus.mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %b expected 1", bus.mosi); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.rxd !== 8'h00) begin errors++; $display("FAIL reset_rxd: got %h expected 00", bus.rxd); end
        $display("reset: nss=%b sck=%b mosi=%b busy=%b rxd=%h", bus.nss, bus.sck, bus.mosi, bus.busy, bus.rxd);
    endtask

    task automatic test_select();
        bus.ss_in = 2'b01;
        bus.ss_we = 1'b1;
        checks++; if (bus.nss !== 2'b11) begin errors++; $display("FAIL select_before_edge: got %b expected 11", bus.nss); end
        step();
        bus.ss_we = 1'b0;
        checks++; if (bus.nss !== 2'b10) begin errors++; $display("FAIL select_mask01: got %b expected 10", bus.nss); end
        $display("select: mask=01 nss=%b", bus.nss);
    endtask

    task automatic test_mode0();
        int lat, rises, lmin, lmax;
        logic [7:0] mseq;
        bit bok, rstab, nstab;
        miso_drv = '0;
        run_xfer(8'hA5, 2'b00, 4'd0, 8'h3C, 1'b1, -1, lat, rises, mseq, lmin, lmax, bok, rstab, nstab);
        $display("mode0: tx=a5 lat=%0d rises=%0d mosi=%h rxd=%h", lat, rises, mseq, bus.rxd);
        checks++; if (lat != 17) begin errors++; $display("FAIL mode0_latency: got %0d expected 17", lat); end
        checks++; if (rises != 8) begin errors++; $display("FAIL mode0_rises: got %0d expected 8", rises); end
        checks++; if (mseq !== 8'hA5) begin errors++; $display("FAIL mode0_mosi: got %h expected a5", mseq); end
        checks++; if (bus.rxd !== 8'h3C) begin errors++; $display("FAIL mode0_rxd: got %h expected 3c", bus.rxd); end
        checks++; if (!bok) begin errors++; $display("FAIL mode0_busy: got bad expected busy=1 in SHIFT, 0 at DONE"); end
        checks++; if (!rstab) begin errors++; $display("FAIL mode0_rxd_stable: got change expected stable until DONE"); end
        checks++; if (bus.sck !== 1'b0) begin errors++; $display("FAIL mode0_sck_done: got %b expected 0", bus.sck); end
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mode0_done_pulse: got %b expected 0", bus.done); end
    endtask

    task automatic test_modes();
        int lat, rises, lmin, lmax;
        logic [7:0] mseq;
        bit bok, rstab, nstab;
        logic [1:0] md;
        logic prev_cpol;
        loopback  = 1'b1;
        prev_cpol = 1'b0;
        for (int i = 1; i < 4; i++) begin
            md = 2'(i);
            checks++; if (bus.sck !== prev_cpol) begin errors++; $display("FAIL mode%0d_sck_before: got %b expected %b", i, bus.sck, prev_cpol); end
            run_xfer(8'h81, md, 4'd0, 8'h00, 1'b0, -1, lat, rises, mseq, lmin, lmax, bok, rstab, nstab);
            $display("mode%0d: tx=81 lat=%0d mosi=%h rxd=%h sck_done=%b", i, lat, mseq, bus.rxd, bus.sck);
            checks++; if (bus.rxd !== 8'h81) begin errors++; $display("FAIL mode%0d_rxd: got %h expected 81", i, bus.rxd); end
            checks++; if (mseq !== 8'h81) begin errors++; $display("FAIL mode%0d_mosi: got %h expected 81", i, mseq); end
            checks++; if (lat != 17) begin errors++; $display("FAIL mode%0d_latency: got %0d expected 17", i, lat); end
            checks++; if (bus.sck !== md[1]) begin errors++; $display("FAIL mode%0d_sck_after: got %b expected %b", i, bus.sck, md[1]); end
            prev_cpol = md[1];
            step();
        end
        loopback = 1'b0;
    endtask

    task automatic test_mix();
        int lat, rises, lmin, lmax;
        logic [7:0] mseq;
        bit bok, rstab, nstab;
        set_mask(2'b00);
        checks++; if (bus.nss !== 2'b11) begin errors++; $display("FAIL mix_nss_none: got %b expected 11", bus.nss); end
        miso_drv = 3'b100;
        run_xfer(8'h00, 2'b00, 4'd0, 8'h00, 1'b0, -1, lat, rises, mseq, lmin, lmax, bok, rstab, nstab);
        $display("mix: mask=00 miso=100 rxd=%h", bus.rxd);
        checks++; if (bus.rxd !== 8'hFF) begin errors++; $display("FAIL mix_default: got %h expected ff", bus.rxd); end
        step();
        set_mask(2'b11);
        checks++; if (bus.nss !== 2'b00) begin errors++; $display("FAIL mix_nss_both: got %b expected 00", bus.nss); end
        miso_drv = 3'b010;
        run_xfer(8'h00, 2'b00, 4'd0, 8'h00, 1'b0, -1, lat, rises, mseq, lmin, lmax, bok, rstab, nstab);
        $display("mix: mask=11 miso=010 rxd=%h", bus.rxd);
        checks++; if (bus.rxd !== 8'hFF) begin errors++; $display("FAIL mix_or: got %h expected ff", bus.rxd); end
        step();
        set_mask(2'b01);
        miso_drv = 3'b110;
        run_xfer(8'h00, 2'b00, 4'd0, 8'h00, 1'b0, -1, lat, rises, mseq, lmin, lmax, bok, rstab, nstab);
        $display("mix: mask=01 miso=110 rxd=%h", bus.rxd);
        checks++; if (bus.rxd !== 8'h00) begin errors++; $display("FAIL mix_unselected: got %h expected 00", bus.rxd); end
        step();
        miso_drv = '0;
    endtask

    task automatic test_div3();
        int lat, rises, lmin, lmax, busy_seen;
        logic [7:0] mseq;
        bit bok, rstab, nstab;
        run_xfer(8'h5A, 2'b00, 4'd3, 8'hC3, 1'b1, 20, lat, rises, mseq, lmin, lmax, bok, rstab, nstab);
        $display("div3: tx=5a lat=%0d level=%0d..%0d mosi=%h rxd=%h", lat, lmin, lmax, mseq, bus.rxd);
        checks++; if (lat != 65) begin errors++; $display("FAIL div3_latency: got %0d expected 65", lat); end
        checks++; if (lmin != 4 || lmax != 4) begin errors++; $display("FAIL div3_level: got %0d..%0d expected 4..4", lmin, lmax); end
        checks++; if (rises != 8) begin errors++; $display("FAIL div3_rises: got %0d expected 8", rises); end
        checks++; if (mseq !== 8'h5A) begin errors++; $display("FAIL div3_mosi: got %h expected 5a", mseq); end
        checks++; if (bus.rxd !== 8'hC3) begin errors++; $display("FAIL div3_rxd: got %h expected c3", bus.rxd); end
        checks++; if (!nstab) begin errors++; $display("FAIL div3_nss_stable: got change expected 10 throughout"); end
        checks++; if (!bok) begin errors++; $display("FAIL div3_busy: got bad expected busy=1 in SHIFT, 0 at DONE"); end
        busy_seen = 0;
        repeat (3) begin
            step();
            if (bus.busy !== 1'b0) busy_seen++;
        end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL div3_no_restart: got %0d busy cycles expected 0", busy_seen); end
        checks++; if (bus.nss !== 2'b10) begin errors++; $display("FAIL div3_nss_after: got %b expected 10", bus.nss); end
    endtask

    task automatic test_reset_mid();
        int lat, rises, lmin, lmax, done_seen;
        logic [7:0] mseq;
        bit bok, rstab, nstab;
        bus.txd = 8'hFF; bus.mode = 2'b10; bus.div = 4'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("reset_mid: busy=%b sck=%b mosi=%b nss=%b done=%b rxd=%h", bus.busy, bus.sck, bus.mosi, bus.nss, bus.done, bus.rxd);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.sck !== 1'b0) begin errors++; $display("FAIL abort_sck: got %b expected 0", bus.sck); end
        checks++; if (bus.mosi !== 1'b1) begin errors++; $display("FAIL abort_mosi: got %b expected 1", bus.mosi); end
        checks++; if (bus.nss !== 2'b11) begin errors++; $display("FAIL abort_nss: got %b expected 11", bus.nss); end
        checks++; if (bus.rxd !== 8'h00) begin errors++; $display("FAIL abort_rxd: got %h expected 00", bus.rxd); end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
            step();
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", done_seen); end
        set_mask(2'b01);
        run_xfer(8'h3C, 2'b00, 4'd0, 8'h96, 1'b1, -1, lat, rises, mseq, lmin, lmax, bok, rstab, nstab);
        $display("after_abort: tx=3c lat=%0d mosi=%h rxd=%h", lat, mseq, bus.rxd);
        checks++; if (lat != 17) begin errors++; $display("FAIL recover_latency: got %0d expected 17", lat); end
        checks++; if (bus.rxd !== 8'h96) begin errors++; $display("FAIL recover_rxd: got %h expected 96", bus.rxd); end
        checks++; if (mseq !== 8'h3C) begin errors++; $display("FAIL recover_mosi: got %h expected 3c", mseq); end
        step();
    endtask

    task automatic test_back_to_back();
        int lat, rises, lmin, lmax;
        logic [7:0] mseq;
        bit bok, rstab, nstab;
        run_xfer(8'hF0, 2'b00, 4'd1, 8'h0F, 1'b1, -1, lat, rises, mseq, lmin, lmax, bok, rstab, nstab);
        $display("b2b_first: tx=f0 lat=%0d rxd=%h", lat, bus.rxd);
        checks++; if (lat != 33) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 33", lat); end
        checks++; if (bus.rxd !== 8'h0F) begin errors++; $display("FAIL b2b_first_rxd: got %h expected 0f", bus.rxd); end
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy: got %b expected 0", bus.busy); end
        run_xfer(8'h55, 2'b00, 4'd1, 8'hAA, 1'b1, -1, lat, rises, mseq, lmin, lmax, bok, rstab, nstab);
        $display("b2b_second: tx=55 lat=%0d mosi=%h rxd=%h", lat, mseq, bus.rxd);
        checks++; if (lat != 33) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 33", lat); end
        checks++; if (!rstab) begin errors++; $display("FAIL b2b_rxd_stable: got change expected 0f until DONE"); end
        checks++; if (bus.rxd !== 8'hAA) begin errors++; $display("FAIL b2b_second_rxd: got %h expected aa", bus.rxd); end
        checks++; if (mseq !== 8'h55) begin errors++; $display("FAIL b2b_second_mosi: got %h expected 55", mseq); end
        step();
    endtask

    initial begin
        test_reset();
        test_select();
        test_mode0();
        test_modes();
        test_mix();
        test_div3();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
